para_serial_buf: RTL and testbench
==================================

// Module: para_serial_buf
// PURPOSE
//  Parametrised, double-buffered parallel-to-serial converter for the NTT datapath.
//  Accepts one frame of LANES coefficients per in_valid/in_ready handshake.
//  Emits the frame one coefficient per out_valid/out_ready beat, with a last-beat flag.
//  Buffering allows gap-free streaming of consecutive frames between the butterfly array and memory.
// PARAMETERS
//  WIDTH  18  coefficient width in bits
//  LANES  8   coefficients per frame (>=2); index counter width IDX_W = $clog2(LANES) (localparam)
// PORTS
//  clock      in   1            single clock; all state updates on rising edge
//  reset      in   1            asynchronous, active-high; clears all state
//  in_valid   in   1            frame present on in_data
//  in_ready   out  1            frame can be accepted (= ~pend_full)
//  in_data    in   LANES*WIDTH  lane k at bits [k*WIDTH +: WIDTH]
//  in_order   in   1            0: lane LANES-1 emitted first; 1: lane 0 first; sampled with frame
//  out_valid  out  1            out_data holds a valid coefficient
//  out_ready  in   1            downstream accepts beat
//  out_data   out  WIDTH        current coefficient
//  out_last   out  1            high with the final beat of a frame
//  busy       out  1            active frame or pending frame held
// BEHAVIOUR
//  - Storage: active register (frame being shifted out) + pending register (next frame); flags act_full, pend_full.
//  - Reset values: out_valid=0, out_last=0, out_data=0, busy=0, act_full=pend_full=0, idx=0, so in_ready=1.
//  - Reset asserted mid-frame: both frames are discarded immediately; no further beats after release until a new accept.
//  - Accept = in_valid & in_ready. Frame and in_order are captured together; order is fixed per frame.
//  - States: IDLE (act_full=0), SHIFT (act_full=1).
//  - IDLE + accept: load active, idx=0, go to SHIFT; out_valid rises next cycle (latency 1).
//  - SHIFT + accept: frame goes to pending.
//    * Exception: if the final beat transfers in the same cycle and pending is empty, the frame goes straight to active.
//  - Beat = out_valid & out_ready: idx increments. out_data, out_valid and out_last are stable while out_ready=0.
//  - Emitted lane is LANES-1-idx (order 0) or idx (order 1).
//  - out_last = out_valid & (idx == LANES-1).
//  - Final beat (idx wraps to 0):
//    * pending full: pending moves to active, pend_full clears, out_valid stays high (no bubble).
//    * else, accept in the same cycle: load active directly.
//    * else: go to IDLE, out_valid=0.
//  - in_ready is combinational from registered pend_full only; no combinational path from out_ready or in_valid.
//  - Throughput: LANES beats per frame, 100% with out_ready held high. At most 2 frames buffered.
//  - busy = act_full | pend_full.
// TESTING
//  - Reset, single frame lanes=10..17, order 0, out_ready=1:
//    out_valid 1 cycle after accept; data 17,16,...,10; out_last on 10; then IDLE.
//  - Same frame with order 1:
//    data 10..17; out_last on 17.
//  - Back-to-back frames A,B,C with in_valid held high:
//    A and B accepted at once; in_ready=0 until A's last beat.
//    24 consecutive beats, no bubble, out_last every 8th beat.
//  - Random out_ready stalls (e.g. 0 every other cycle):
//    out_data, out_last held while stalled; sequence and count identical to the unstalled run.
//  - Accept coinciding with final beat while pending empty:
//    new frame starts the next cycle with no gap; in_ready stays 1.
//  - Reset pulse at idx=3 with pending full:
//    out_valid=0 and busy=0 during reset; after release no beats until a new frame, which then emits normally.

Source files
------------

// File: rtl/para_serial_buf.sv
// Double-buffered parallel-to-serial converter: one LANES-wide frame in per handshake,
// one coefficient out per beat, with an active and a pending frame register.
module para_serial_buf #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned LANES = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_order,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  output logic                   busy
);

  localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e                 state_q;
  logic [LANES*WIDTH-1:0] act_q;
  logic [LANES*WIDTH-1:0] pend_q;
  logic                   act_ord_q;
  logic                   pend_ord_q;
  logic                   pend_full_q;
  logic [IDX_W-1:0]       idx_q;

  logic                   accept_c;
  logic                   beat_c;
  logic                   final_c;
  logic [IDX_W-1:0]       lane_c;
  logic [WIDTH-1:0]       lane_w [LANES];

  // in_ready depends only on registered pending state, never on out_ready/in_valid
  assign in_ready  = ~pend_full_q;
  assign out_valid = (state_q == SHIFT);
  assign busy      = out_valid | pend_full_q;
  assign out_last  = out_valid & (idx_q == LAST_IDX);

  assign accept_c  = in_valid & ~pend_full_q;
  assign beat_c    = out_valid & out_ready;
  assign final_c   = beat_c & (idx_q == LAST_IDX);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_w[g] = act_q[g*WIDTH +: WIDTH];
  end

  assign lane_c   = act_ord_q ? idx_q : (LAST_IDX - idx_q);
  assign out_data = lane_w[lane_c];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      act_q       <= '0;
      pend_q      <= '0;
      act_ord_q   <= 1'b0;
      pend_ord_q  <= 1'b0;
      pend_full_q <= 1'b0;
      idx_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            act_q     <= in_data;
            act_ord_q <= in_order;
            idx_q     <= '0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (beat_c) begin
            idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
          end
          // Final beat refills active from pending, else from the input, else drains to idle
          if (final_c) begin
            if (pend_full_q) begin
              act_q       <= pend_q;
              act_ord_q   <= pend_ord_q;
              pend_full_q <= 1'b0;
            end else if (accept_c) begin
              act_q     <= in_data;
              act_ord_q <= in_order;
            end else begin
              state_q <= IDLE;
            end
          end else if (accept_c) begin
            pend_q      <= in_data;
            pend_ord_q  <= in_order;
            pend_full_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_para_serial_buf.sv
// Self-checking bench for para_serial_buf: vector table for single frames plus
// directed sequences for back-to-back, stalls, accept-on-final-beat and mid-frame reset.
module tb_para_serial_buf;

  localparam int unsigned WIDTH = 18;
  localparam int unsigned LANES = 8;
  localparam int unsigned NROWS = 19;

  logic                   clock;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_data;
  logic                   in_order;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic                   out_last;
  logic                   busy;

  int n_checks;
  int n_errors;

  para_serial_buf #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_order (in_order),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic                   iv;
    logic [LANES*WIDTH-1:0] d;
    logic                   ord;
    logic                   ordy;
    logic                   ev;
    logic [WIDTH-1:0]       ed;
    logic                   elast;
    logic                   eir;
    logic                   ebusy;
  } vec_t;

  vec_t tbl [NROWS];

  int fr_base [4];
  int fr_ord  [4];
  int acc_cyc [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [LANES*WIDTH-1:0] mk_frame(input int base);
    logic [LANES*WIDTH-1:0] f;
    f = '0;
    for (int k = 0; k < LANES; k++) f[k*WIDTH +: WIDTH] = WIDTH'(base + k);
    return f;
  endfunction

  function automatic int exp_lane_val(input int base, input int ord, input int k);
    return (ord != 0) ? base + k : base + (LANES - 1 - k);
  endfunction

  // Streams nfr frames from fr_base/fr_ord; mode 0 = out_ready high, 1 = ready every other cycle
  task automatic stream(input int mode, input int nfr, input bit no_bubble);
    int fi, bi, cyc, bubbles, f, k;
    logic prev_stall, rdy;
    logic [WIDTH-1:0] prev_data;
    logic prev_last;
    fi = 0; bi = 0; cyc = 0; bubbles = 0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    while (bi < nfr * LANES && cyc < 400) begin
      @(negedge clock);
      if (prev_stall) begin
        chk("stall_valid_held", 32'(out_valid), 32'd1);
        chk("stall_data_held", 32'(out_data), 32'(prev_data));
        chk("stall_last_held", 32'(out_last), 32'(prev_last));
      end
      rdy = (mode == 0) ? 1'b1 : cyc[0];
      out_ready = rdy;
      if (fi < nfr) begin
        in_valid = 1'b1;
        in_data  = mk_frame(fr_base[fi]);
        in_order = fr_ord[fi][0];
        if (in_ready) begin
          acc_cyc[fi] = cyc;
          fi++;
        end
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        if (rdy) begin
          f = bi / LANES;
          k = bi % LANES;
          chk("beat_data", 32'(out_data), 32'(exp_lane_val(fr_base[f], fr_ord[f], k)));
          chk("beat_last", 32'(out_last), 32'(k == LANES - 1));
          bi++;
        end
      end else if (bi > 0) begin
        bubbles++;
      end
      prev_stall = out_valid & ~rdy;
      prev_data  = out_data;
      prev_last  = out_last;
      cyc++;
    end
    chk("stream_beat_count", 32'(bi), 32'(nfr * LANES));
    chk("stream_frames_accepted", 32'(fi), 32'(nfr));
    if (no_bubble) chk("stream_bubbles", 32'(bubbles), 32'd0);
    @(negedge clock);
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_idle_after", 32'(out_valid), 32'd0);
    chk("stream_busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int cnt;
    logic [LANES*WIDTH-1:0] f10;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_order = 1'b0;
    out_ready = 1'b1;

    // Single frame lanes 10..17: order 0 then order 1
    f10 = mk_frame(10);
    for (int i = 0; i < NROWS; i++) begin
      tbl[i].iv = 1'b0; tbl[i].d = f10; tbl[i].ord = 1'b0; tbl[i].ordy = 1'b1;
      tbl[i].ev = 1'b0; tbl[i].ed = '0; tbl[i].elast = 1'b0;
      tbl[i].eir = 1'b1; tbl[i].ebusy = 1'b0;
    end
    tbl[0].iv = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tbl[i].ev = 1'b1; tbl[i].ebusy = 1'b1;
      tbl[i].ed = WIDTH'(10 + (8 - i));
      tbl[i].elast = (i == 8);
    end
    tbl[9].iv = 1'b1; tbl[9].ord = 1'b1;
    for (int i = 10; i <= 17; i++) begin
      tbl[i].ev = 1'b1; tbl[i].ebusy = 1'b1;
      tbl[i].ed = WIDTH'(10 + (i - 10));
      tbl[i].elast = (i == 17);
    end

    repeat (2) @(negedge clock);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_last", 32'(out_last), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;

    for (int i = 0; i < NROWS; i++) begin
      @(negedge clock);
      chk("tbl_out_valid", 32'(out_valid), 32'(tbl[i].ev));
      chk("tbl_in_ready", 32'(in_ready), 32'(tbl[i].eir));
      chk("tbl_busy", 32'(busy), 32'(tbl[i].ebusy));
      chk("tbl_out_last", 32'(out_last), 32'(tbl[i].elast));
      if (tbl[i].ev) chk("tbl_out_data", 32'(out_data), 32'(tbl[i].ed));
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].d;
      in_order  = tbl[i].ord;
      out_ready = tbl[i].ordy;
    end

    // Back-to-back A,B,C with in_valid held high: 24 gap-free beats
    fr_base[0] = 100; fr_base[1] = 200; fr_base[2] = 300;
    fr_ord[0] = 0; fr_ord[1] = 1; fr_ord[2] = 0;
    stream(0, 3, 1'b1);
    chk("b2b_accept_A_cycle", 32'(acc_cyc[0]), 32'd0);
    chk("b2b_accept_B_cycle", 32'(acc_cyc[1]), 32'd1);
    chk("b2b_accept_C_cycle", 32'(acc_cyc[2]), 32'd9);

    // Same frames with out_ready low every other cycle
    stream(1, 3, 1'b0);

    // Accept coinciding with final beat while pending is empty
    @(negedge clock);
    in_valid = 1'b1; in_data = mk_frame(700); in_order = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    cnt = 0;
    while (!out_last && cnt < 20) begin
      @(negedge clock);
      cnt++;
    end
    chk("fin_reached_last", 32'(out_last), 32'd1);
    chk("fin_in_ready_at_last", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = mk_frame(800); in_order = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    chk("fin_no_gap_valid", 32'(out_valid), 32'd1);
    chk("fin_new_first_data", 32'(out_data), 32'd800);
    chk("fin_in_ready_after", 32'(in_ready), 32'd1);
    for (int k = 1; k < LANES; k++) begin
      @(negedge clock);
      chk("fin_new_data", 32'(out_data), 32'(800 + k));
      chk("fin_new_last", 32'(out_last), 32'(k == LANES - 1));
    end
    @(negedge clock);
    chk("fin_idle_after", 32'(out_valid), 32'd0);

    // Reset pulse at idx=3 with pending full
    in_valid = 1'b1; in_data = mk_frame(400); in_order = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    in_data = mk_frame(500);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_pre_data_idx3", 32'(out_data), 32'(400 + 4));
    chk("rst_pre_pend_full", 32'(in_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("rst_during_valid", 32'(out_valid), 32'd0);
    chk("rst_during_busy", 32'(busy), 32'd0);
    chk("rst_during_in_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    chk("rst_during_valid2", 32'(out_valid), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("rst_after_valid", 32'(out_valid), 32'd0);
      chk("rst_after_busy", 32'(busy), 32'd0);
    end
    fr_base[0] = 600; fr_ord[0] = 1;
    stream(0, 1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
